// File: rtl/quad_encoder_gen_pkg.sv
// rtl/quad_encoder_gen_pkg.sv - quadrature phase encoding and step helpers
package quad_gen_pkg;

  // Enum values equal the (a,b) pair, so decoding a phase is a plain cast.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  function automatic phase_t next_phase(input phase_t ph, input logic dir);
    phase_t nx;
    nx = PH_00;
    case (ph)
      PH_00:   nx = dir ? PH_01 : PH_10;
      PH_01:   nx = dir ? PH_11 : PH_00;
      PH_11:   nx = dir ? PH_10 : PH_01;
      PH_10:   nx = dir ? PH_00 : PH_11;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

  function automatic logic [1:0] phase_to_ab(input phase_t ph);
    return 2'(ph);
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// rtl/quad_encoder_gen_if.sv - command and encoder output bundle
interface quad_encoder_gen_if #(
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 32
);
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic                dir;
  logic                a;
  logic                b;
  logic                z;
  logic [POS_W-1:0]    pos;
  logic                stalled;

  modport master (
    output enable, period, dir,
    input  a, b, z, pos, stalled
  );

  modport slave (
    input  enable, period, dir,
    output a, b, z, pos, stalled
  );
endinterface

// File: rtl/quad_encoder_gen_quarter_timer.sv
// rtl/quad_encoder_gen_quarter_timer.sv - quarter-step timer with step-boundary period load
module quarter_timer #(
  parameter int PERIOD_W = 16,
  parameter int PRESCALE = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                step,
  output logic                stalled
);

  localparam int CNT_W = PERIOD_W + PRESCALE;

  logic [PERIOD_W-1:0] act_period;
  logic [PERIOD_W-1:0] eff_period;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    q_last;
  logic                running;
  logic                load;

  // While stalled the command is used directly, so restarts count a full Q
  // from the first running cycle instead of waiting one cycle for the load.
  always_comb begin
    eff_period = stalled ? period : act_period;
    running    = enable && (eff_period != '0);
    q_last     = (CNT_W'(eff_period) << PRESCALE) - CNT_W'(1);
    step       = running && (cnt == q_last);
    load       = stalled || !running || step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      act_period <= '0;
      stalled    <= 1'b1;
    end else begin
      stalled <= !running;
      if (!running || step) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load) begin
        act_period <= period;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// rtl/quad_encoder_gen.sv - quadrature encoder emulator: A/B/Z and signed position
module quad_encoder_gen
  import quad_gen_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int PRESCALE = 10,
  parameter int CPR      = 1024,
  parameter int POS_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  quad_encoder_gen_if.slave io
);

  localparam int STEPS_REV = 4 * CPR;
  localparam int IDX_W     = (STEPS_REV > 1) ? $clog2(STEPS_REV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS_REV - 1);

  phase_t           phase;
  phase_t           phase_nx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nx;
  logic [POS_W-1:0] pos_r;
  logic [POS_W-1:0] pos_nx;
  logic             a_r;
  logic             b_r;
  logic             z_r;
  logic             step;
  logic             stalled_w;

  quarter_timer #(
    .PERIOD_W (PERIOD_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (io.enable),
    .period  (io.period),
    .step    (step),
    .stalled (stalled_w)
  );

  // dir only matters on the step cycle; the registers below update only then.
  always_comb begin
    phase_nx = next_phase(phase, io.dir);
    idx_nx   = idx;
    pos_nx   = pos_r;
    if (io.dir) begin
      idx_nx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      pos_nx = pos_r + POS_W'(1);
    end else begin
      idx_nx = (idx == '0) ? IDX_LAST : idx - IDX_W'(1);
      pos_nx = pos_r - POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_00;
      idx   <= '0;
      pos_r <= '0;
      a_r   <= 1'b0;
      b_r   <= 1'b0;
      z_r   <= 1'b0;
    end else if (step) begin
      phase      <= phase_nx;
      {a_r, b_r} <= phase_to_ab(phase_nx);
      idx        <= idx_nx;
      pos_r      <= pos_nx;
      z_r        <= (idx_nx == '0);
    end
  end

  assign io.a       = a_r;
  assign io.b       = b_r;
  assign io.z       = z_r;
  assign io.pos     = pos_r;
  assign io.stalled = stalled_w;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb/tb_quad_encoder_gen.sv - scoreboard bench for quad_encoder_gen
module tb_quad_encoder_gen;

  localparam int PW  = 8;
  localparam int PS  = 2;
  localparam int CP  = 2;
  localparam int PSW = 4;

  typedef struct {
    logic [1:0] ab;
    logic       z;
    logic [3:0] pos;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t q[$];
  exp_t mon_e;
  logic pa = 1'b0;
  logic pb = 1'b0;
  logic pz = 1'b0;
  logic [3:0] ppos = 4'd0;

  int m_k = 0;
  int m_pos = 0;
  int m_idx = 0;
  logic [1:0] ab_tab [4];

  quad_encoder_gen_if #(.PERIOD_W(PW), .POS_W(PSW)) bus ();

  quad_encoder_gen #(
    .PERIOD_W (PW),
    .PRESCALE (PS),
    .CPR      (CP),
    .POS_W    (PSW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      pa = bus.a; pb = bus.b; pz = bus.z; ppos = bus.pos;
    end else if ({bus.a, bus.b, bus.z, bus.pos} !== {pa, pb, pz, ppos}) begin
      checks++;
      if ((bus.a ^ pa) == (bus.b ^ pb)) begin
        errors++;
        $display("FAIL single_toggle: ab %b%b -> %b%b, required exactly one channel to toggle",
                 pa, pb, bus.a, bus.b);
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: ab=%b%b z=%b pos=%0d at cycle %0d, required no change",
                 bus.a, bus.b, bus.z, bus.pos, cyc);
      end else begin
        mon_e = q.pop_front();
        if ({bus.a, bus.b} !== mon_e.ab || bus.z !== mon_e.z || bus.pos !== mon_e.pos ||
            cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL step_output: got ab=%b%b z=%b pos=%0d cyc=%0d, required ab=%b z=%b pos=%0d cyc=%0d",
                   bus.a, bus.b, bus.z, bus.pos, cyc, mon_e.ab, mon_e.z, mon_e.pos, mon_e.cyc);
        end
      end
      pa = bus.a; pb = bus.b; pz = bus.z; ppos = bus.pos;
    end
  end

  task automatic push_step(input logic d, input int at);
    exp_t e;
    if (d) begin
      m_k = (m_k + 1) % 4; m_pos = (m_pos + 1) % 16; m_idx = (m_idx + 1) % 8;
    end else begin
      m_k = (m_k + 3) % 4; m_pos = (m_pos + 15) % 16; m_idx = (m_idx + 7) % 8;
    end
    e.ab  = ab_tab[m_k];
    e.z   = (m_idx == 0);
    e.pos = 4'(m_pos);
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected steps never appeared, required 0", name, q.size());
      q.delete();
    end
  endtask

  // Runs n steps at period 1 (Q=4); bit i of dm is the direction of step i.
  task automatic run_steps(input string name, input int n, input logic [31:0] dm);
    int c;
    @(negedge clk);
    checks++;
    if (bus.stalled !== 1'b1) begin
      errors++;
      $display("FAIL %s_stalled_before: got %b, required 1", name, bus.stalled);
    end
    c = cyc;
    bus.period = 8'd1;
    bus.dir    = dm[0];
    bus.enable = 1'b1;
    for (int i = 0; i < n; i++) push_step(dm[i], c + 4 * (i + 1));
    wait_cyc(c + 1);
    checks++;
    if (bus.stalled !== 1'b0) begin
      errors++;
      $display("FAIL %s_stalled_running: got %b, required 0", name, bus.stalled);
    end
    for (int i = 0; i < n; i++) begin
      wait_cyc(c + 4 * (i + 1));
      if (i < n - 1) bus.dir = dm[i + 1];
      else bus.enable = 1'b0;
    end
    check_drained(name);
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.period = '0; bus.dir = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.a, bus.b, bus.z} !== 3'b000) begin
      errors++;
      $display("FAIL reset_abz: got %b%b%b, required 000", bus.a, bus.b, bus.z);
    end
    checks++;
    if (bus.pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_pos: got %0d, required 0", bus.pos);
    end
    checks++;
    if (bus.stalled !== 1'b1) begin
      errors++;
      $display("FAIL reset_stalled: got %b, required 1", bus.stalled);
    end
    rst = 1'b0;
    bus.enable = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.stalled !== 1'b1 || bus.pos !== 4'd0) begin
      errors++;
      $display("FAIL zero_period_stall: got stalled=%b pos=%0d, required stalled=1 pos=0",
               bus.stalled, bus.pos);
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_forward();
    run_steps("forward", 4, 32'h0000_000F);
  endtask

  task automatic test_reversal();
    run_steps("reversal", 7, 32'h0000_0003);
  endtask

  task automatic test_period_change();
    int c;
    @(negedge clk);
    c = cyc;
    bus.period = 8'd1; bus.dir = 1'b1; bus.enable = 1'b1;
    push_step(1'b1, c + 4);
    push_step(1'b1, c + 16);
    push_step(1'b1, c + 28);
    wait_cyc(c + 2);
    bus.period = 8'd3;
    wait_cyc(c + 28);
    bus.enable = 1'b0;
    check_drained("period_change");
  endtask

  task automatic test_stall();
    int c;
    @(negedge clk);
    c = cyc;
    bus.period = 8'd1; bus.dir = 1'b1; bus.enable = 1'b1;
    push_step(1'b1, c + 4);
    push_step(1'b1, c + 8);
    wait_cyc(c + 6);
    bus.period = 8'd0;
    wait_cyc(c + 9);
    checks++;
    if (bus.stalled !== 1'b1) begin
      errors++;
      $display("FAIL stall_enter: got stalled=%b, required 1", bus.stalled);
    end
    wait_cyc(c + 20);
    checks++;
    if (bus.stalled !== 1'b1 || bus.pos !== 4'(m_pos)) begin
      errors++;
      $display("FAIL stall_hold: got stalled=%b pos=%0d, required stalled=1 pos=%0d",
               bus.stalled, bus.pos, m_pos);
    end
    bus.period = 8'd1;
    push_step(1'b1, c + 24);
    wait_cyc(c + 21);
    checks++;
    if (bus.stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_exit: got stalled=%b, required 0", bus.stalled);
    end
    wait_cyc(c + 24);
    bus.enable = 1'b0;
    check_drained("stall");
    // enable dropping during the step cycle must swallow that step
    @(negedge clk);
    c = cyc;
    bus.enable = 1'b1;
    wait_cyc(c + 3);
    bus.enable = 1'b0;
    wait_cyc(c + 10);
    checks++;
    if (bus.pos !== 4'(m_pos) || bus.stalled !== 1'b1) begin
      errors++;
      $display("FAIL enable_fall_step: got pos=%0d stalled=%b, required pos=%0d stalled=1",
               bus.pos, bus.stalled, m_pos);
    end
  endtask

  task automatic test_index_wrap();
    run_steps("index_wrap", 13, 32'h0000_0DFF);
  endtask

  task automatic test_async_reset();
    int c;
    @(negedge clk);
    c = cyc;
    bus.period = 8'd1; bus.dir = 1'b1; bus.enable = 1'b1;
    wait_cyc(c + 2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.a, bus.b, bus.z} !== 3'b000 || bus.pos !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got ab=%b%b z=%b pos=%0d, required all 0",
               bus.a, bus.b, bus.z, bus.pos);
    end
    checks++;
    if (bus.stalled !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_stalled: got %b, required 1", bus.stalled);
    end
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_k = 0; m_pos = 0; m_idx = 0;
    run_steps("after_reset", 2, 32'h0000_0003);
  endtask

  initial begin
    ab_tab[0] = 2'b00; ab_tab[1] = 2'b01; ab_tab[2] = 2'b11; ab_tab[3] = 2'b10;
    test_reset();
    test_forward();
    test_reversal();
    test_period_change();
    test_stall();
    test_index_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
